// File: rtl/bt_pkg.sv
// Shared constants and state encoding for the RX payload bit packer.
// Build option: PYRX_LENCHK_EN enables the payload length check in pyrx_bit_packer.
package bt_pkg;
   localparam int WORD_W   = 32;
   localparam int ADDR_W   = 8;
   localparam int MAX_BITS = 8192;
   localparam int IDX_W    = $clog2(WORD_W);
   localparam int BITCNT_W = $clog2(MAX_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } bt_state_e;

   // Byte length to bit count, truncated to the bit counter width.
   function automatic logic [BITCNT_W-1:0] len_to_bits(input logic [9:0] len_bytes);
      return {len_bytes, 3'b000};
   endfunction
endpackage

// File: rtl/pyrx_bit_packer_if.sv
// Decoder-to-packer bit stream plus packer-to-buffer write port.
interface pyrx_bit_packer_if;
   import bt_pkg::*;

   // dec_pybit_vld and py_endp are single-cycle strobes with no back-pressure:
   // the packer samples them on every clk_6M edge and never stalls the decoder.
   logic                dec_py_period;
   logic                dec_pybit;
   logic                dec_pybit_vld;
   logic                py_endp;
   logic                dec_crcgood;
   logic [9:0]          dec_pylenByte;
   logic [ADDR_W-1:0]   rxlnctrl_addr;
   logic [WORD_W-1:0]   rxlnctrl_din;
   logic                rxlnctrl_we;
   logic                rxbsm_valid_p;
   logic                rx_ovf;
   logic                rx_lenerr;

   modport master (
      output dec_py_period, dec_pybit, dec_pybit_vld, py_endp, dec_crcgood, dec_pylenByte,
      input  rxlnctrl_addr, rxlnctrl_din, rxlnctrl_we, rxbsm_valid_p, rx_ovf, rx_lenerr
   );

   modport slave (
      input  dec_py_period, dec_pybit, dec_pybit_vld, py_endp, dec_crcgood, dec_pylenByte,
      output rxlnctrl_addr, rxlnctrl_din, rxlnctrl_we, rxbsm_valid_p, rx_ovf, rx_lenerr
   );
endinterface

// File: rtl/pyrx_wordacc.sv
// 32-bit LSB-first word accumulator: writes one bit at a given index, clear wins.
module pyrx_wordacc
   import bt_pkg::*;
(
   input  logic              clk_6M,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [IDX_W-1:0]  idx,
   input  logic              bit_in,
   output logic [WORD_W-1:0] word,
   output logic [WORD_W-1:0] word_nxt
);
   always_comb begin
      word_nxt = word;
      if (wr) word_nxt[idx] = bit_in;
   end

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst)      word <= '0;
      else if (clr) word <= '0;
      else          word <= word_nxt;
   end
endmodule

// File: rtl/pyrx_bit_packer.sv
// Packs decoded payload bits into 32-bit words for the RX payload buffer.
// Build option: PYRX_LENCHK_EN adds the received-length vs dec_pylenByte check.
module pyrx_bit_packer
   import bt_pkg::*;
(
   input  logic               clk_6M,
   input  logic               rst,
   pyrx_bit_packer_if.slave   bus,
   output bt_state_e          state_dbg
);
   bt_state_e           state, state_nxt;
   logic                py_period_q;
   logic [BITCNT_W-1:0] bitcnt, bitcnt_nxt;
   logic                full;
   logic                crc_q;
   logic                ovf_q;
   logic                lenerr;
   logic                valid_p;
   logic [WORD_W-1:0]   acc_word, acc_word_nxt;

   logic start, accept, drop, word_done, flush_wr, endp_hit;

   assign start      = (state == IDLE) && bus.dec_py_period && !py_period_q;
   assign accept     = (state == PACK) && bus.dec_pybit_vld && !full;
   assign drop       = (state == PACK) && bus.dec_pybit_vld && full;
   assign endp_hit   = (state == PACK) && bus.py_endp;
   assign word_done  = accept && (bitcnt[IDX_W-1:0] == '1);
   assign flush_wr   = (state == FLUSH) && (bitcnt[IDX_W-1:0] != '0);
   assign bitcnt_nxt = bitcnt + BITCNT_W'(accept);

   pyrx_wordacc u_wordacc (
      .clk_6M   (clk_6M),
      .rst      (rst),
      .clr      (start || word_done),
      .wr       (accept),
      .idx      (bitcnt[IDX_W-1:0]),
      .bit_in   (bus.dec_pybit),
      .word     (acc_word),
      .word_nxt (acc_word_nxt)
   );

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      valid_p   = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = PACK;
         PACK: begin
            if (bus.py_endp)             state_nxt = FLUSH;
            else if (!bus.dec_py_period) state_nxt = IDLE;
         end
         FLUSH: state_nxt = DONE;
         DONE: begin
            valid_p   = crc_q && !ovf_q && !lenerr;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset to 1 so a period already high at reset release is not taken as a new start.
   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) py_period_q <= 1'b1;
      else     py_period_q <= bus.dec_py_period;
   end

   // full marks that bit MAX_BITS-1 was stored; bitcnt has wrapped and further bits are dropped.
   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         bitcnt <= '0;
         full   <= 1'b0;
         ovf_q  <= 1'b0;
         crc_q  <= 1'b0;
      end else if (start) begin
         bitcnt <= '0;
         full   <= 1'b0;
         ovf_q  <= 1'b0;
         crc_q  <= 1'b0;
      end else begin
         if (accept) bitcnt <= bitcnt_nxt;
         if (accept && (bitcnt == BITCNT_W'(MAX_BITS - 1))) full <= 1'b1;
         if (drop) ovf_q <= 1'b1;
         if (endp_hit) crc_q <= bus.dec_crcgood;
      end
   end

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         bus.rxlnctrl_we   <= 1'b0;
         bus.rxlnctrl_addr <= '0;
         bus.rxlnctrl_din  <= '0;
      end else begin
         bus.rxlnctrl_we <= word_done || flush_wr;
         if (word_done) begin
            bus.rxlnctrl_addr <= bitcnt[BITCNT_W-1:IDX_W];
            bus.rxlnctrl_din  <= acc_word_nxt;
         end else if (flush_wr) begin
            bus.rxlnctrl_addr <= bitcnt[BITCNT_W-1:IDX_W];
            bus.rxlnctrl_din  <= acc_word;
         end
      end
   end

`ifdef PYRX_LENCHK_EN
   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst)           lenerr <= 1'b0;
      else if (start)    lenerr <= 1'b0;
      else if (endp_hit) lenerr <= (bitcnt_nxt != len_to_bits(bus.dec_pylenByte));
   end
`else
   assign lenerr = 1'b0;
`endif

   assign bus.rx_ovf        = ovf_q;
   assign bus.rx_lenerr     = lenerr;
   assign bus.rxbsm_valid_p = valid_p;
   assign state_dbg         = state;
endmodule

// File: tb/tb_pyrx_bit_packer.sv
// Directed bench for pyrx_bit_packer: vector table plus abort and mid-payload reset sequences.
module tb_pyrx_bit_packer;
   import bt_pkg::*;

`ifdef PYRX_LENCHK_EN
   localparam bit LENCHK = 1'b1;
`else
   localparam bit LENCHK = 1'b0;
`endif

   typedef struct {
      int          nbits;
      logic [31:0] pat;
      logic        crc;
      logic [9:0]  lenb;
      logic        endp_last;
      logic        gaps;
      int          exp_nwr;
      logic [31:0] exp_din_last;
      logic        exp_valid_nochk;
      logic        exp_ovf;
      logic        exp_lenerr_chk;
   } vec_t;

   logic      clk_6M = 1'b0;
   logic      rst    = 1'b1;
   bt_state_e state_dbg;

   pyrx_bit_packer_if bus();

   pyrx_bit_packer dut (
      .clk_6M    (clk_6M),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   always #83 clk_6M = ~clk_6M;

   int total = 0;
   int bad   = 0;
   int valid_cnt = 0;
   logic [39:0] exp_q[$];
   logic [39:0] act_q[$];

   always @(negedge clk_6M) begin
      if (bus.rxlnctrl_we) act_q.push_back({bus.rxlnctrl_addr, bus.rxlnctrl_din});
      if (bus.rxbsm_valid_p) valid_cnt++;
   end

   initial begin
      repeat (30000) @(posedge clk_6M);
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_6M);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=%h req=%h", name, act, exp);
      end
   endtask

   task automatic model_words(input int nbits, input logic [31:0] pat);
      int n;
      n = (nbits > MAX_BITS) ? MAX_BITS : nbits;
      for (int k = 0; k < n / 32; k++) exp_q.push_back({8'(k), pat});
      if (n % 32 != 0) exp_q.push_back({8'(n / 32), pat & ((32'd1 << (n % 32)) - 32'd1)});
   endtask

   task automatic compare_writes(input string name);
      logic [39:0] e, a;
      check({name, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 40'hxx_xxxx_xxxx;
         check({name, "_wr"}, 64'(a), 64'(e));
      end
      act_q.delete();
   endtask

   task automatic send_payload(input int nbits, input logic [31:0] pat, input logic crc,
                               input logic [9:0] lenb, input logic endp_last, input logic gaps);
      bus.dec_pylenByte = lenb;
      bus.dec_py_period = 1'b1;
      tick();
      tick();
      for (int i = 0; i < nbits; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         bus.dec_pybit_vld = 1'b1;
         bus.dec_pybit     = pat[i % 32];
         if (endp_last && i == nbits - 1) begin
            bus.py_endp     = 1'b1;
            bus.dec_crcgood = crc;
         end
         tick();
         bus.dec_pybit_vld = 1'b0;
         bus.py_endp       = 1'b0;
         bus.dec_crcgood   = 1'b0;
      end
      if (!endp_last) begin
         bus.py_endp     = 1'b1;
         bus.dec_crcgood = crc;
         tick();
         bus.py_endp     = 1'b0;
         bus.dec_crcgood = 1'b0;
      end
      bus.dec_py_period = 1'b0;
      repeat (4) tick();
   endtask

   vec_t vecs[7];

   initial begin
      int v0;
      logic [39:0] last_wr;

      vecs[0] = '{40,   32'h5555_5555, 1'b1, 10'd5,    1'b1, 1'b1, 2,   32'h0000_0055, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{64,   32'hFFFF_FFFF, 1'b1, 10'd8,    1'b1, 1'b0, 2,   32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{40,   32'h5555_5555, 1'b0, 10'd5,    1'b1, 1'b1, 2,   32'h0000_0055, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8200, 32'h8000_0001, 1'b1, 10'd1023, 1'b0, 1'b0, 256, 32'h8000_0001, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{24,   32'hFFA5_A5A5, 1'b1, 10'd2,    1'b1, 1'b0, 1,   32'h00A5_A5A5, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{32,   32'hDEAD_BEEF, 1'b1, 10'd4,    1'b0, 1'b1, 1,   32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1,    32'h0000_0001, 1'b1, 10'd0,    1'b1, 1'b0, 1,   32'h0000_0001, 1'b1, 1'b0, 1'b1};

      bus.dec_py_period = 1'b0;
      bus.dec_pybit     = 1'b0;
      bus.dec_pybit_vld = 1'b0;
      bus.py_endp       = 1'b0;
      bus.dec_crcgood   = 1'b0;
      bus.dec_pylenByte = '0;

      // Reset state
      repeat (3) tick();
      check("rst_we",     64'(bus.rxlnctrl_we),   64'd0);
      check("rst_addr",   64'(bus.rxlnctrl_addr), 64'd0);
      check("rst_din",    64'(bus.rxlnctrl_din),  64'd0);
      check("rst_valid",  64'(bus.rxbsm_valid_p), 64'd0);
      check("rst_ovf",    64'(bus.rx_ovf),        64'd0);
      check("rst_lenerr", 64'(bus.rx_lenerr),     64'd0);
      check("rst_state",  64'(state_dbg),         64'(IDLE));
      rst = 1'b0;
      tick();

      for (int t = 0; t < 7; t++) begin
         v0 = valid_cnt;
         act_q.delete();
         model_words(vecs[t].nbits, vecs[t].pat);
         last_wr = exp_q[exp_q.size() - 1];
         check($sformatf("v%0d_last_din_hand", t), 64'(last_wr[31:0]), 64'(vecs[t].exp_din_last));
         send_payload(vecs[t].nbits, vecs[t].pat, vecs[t].crc, vecs[t].lenb,
                      vecs[t].endp_last, vecs[t].gaps);
         check($sformatf("v%0d_nwr_hand", t), 64'(act_q.size()), 64'(vecs[t].exp_nwr));
         compare_writes($sformatf("v%0d", t));
         check($sformatf("v%0d_valid", t), 64'(valid_cnt - v0),
               64'(vecs[t].exp_valid_nochk && !(LENCHK && vecs[t].exp_lenerr_chk)));
         check($sformatf("v%0d_ovf", t), 64'(bus.rx_ovf), 64'(vecs[t].exp_ovf));
         check($sformatf("v%0d_lenerr", t), 64'(bus.rx_lenerr), 64'(LENCHK && vecs[t].exp_lenerr_chk));
         check($sformatf("v%0d_hold_we", t), 64'(bus.rxlnctrl_we), 64'd0);
         check($sformatf("v%0d_hold_bus", t), 64'({bus.rxlnctrl_addr, bus.rxlnctrl_din}), 64'(last_wr));
         check($sformatf("v%0d_state", t), 64'(state_dbg), 64'(IDLE));
      end

      // Abort: period falls without py_endp after 40 bits
      v0 = valid_cnt;
      bus.dec_pylenByte = 10'd5;
      bus.dec_py_period = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 40; i++) begin
         bus.dec_pybit_vld = 1'b1;
         bus.dec_pybit     = (i % 2 == 0);
         tick();
         bus.dec_pybit_vld = 1'b0;
      end
      bus.dec_py_period = 1'b0;
      repeat (5) tick();
      exp_q.push_back({8'd0, 32'h5555_5555});
      compare_writes("abort");
      check("abort_valid", 64'(valid_cnt - v0), 64'd0);
      check("abort_state", 64'(state_dbg), 64'(IDLE));

      // Reset mid-payload after 20 bits, strobes ignored until a new period edge
      bus.dec_py_period = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         bus.dec_pybit_vld = 1'b1;
         bus.dec_pybit     = 1'b1;
         tick();
         bus.dec_pybit_vld = 1'b0;
      end
      rst = 1'b1;
      tick();
      tick();
      check("mid_rst_we",    64'(bus.rxlnctrl_we), 64'd0);
      check("mid_rst_bus",   64'({bus.rxlnctrl_addr, bus.rxlnctrl_din}), 64'd0);
      check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
      rst = 1'b0;
      tick();
      for (int i = 0; i < 40; i++) begin
         bus.dec_pybit_vld = 1'b1;
         bus.dec_pybit     = 1'b1;
         tick();
         bus.dec_pybit_vld = 1'b0;
      end
      repeat (3) tick();
      check("idle_strobes_nwr", 64'(act_q.size()), 64'd0);
      check("idle_strobes_state", 64'(state_dbg), 64'(IDLE));
      act_q.delete();
      bus.dec_py_period = 1'b0;
      tick();
      v0 = valid_cnt;
      send_payload(8, 32'h0000_00A5, 1'b1, 10'd1, 1'b1, 1'b0);
      exp_q.push_back({8'd0, 32'h0000_00A5});
      compare_writes("after_rst");
      check("after_rst_valid", 64'(valid_cnt - v0), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pyrx_bit_packer.md
PYRX_BIT_PACKER -- requirements
Module: pyrx_bit_packer

Interface
REQ-001 SHALL have port clk_6M  input  1  6 MHz system clock; all state on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port dec_py_period  input  1  high while the decoder delivers payload bits.
REQ-004 SHALL have port dec_pybit  input  1  decoded payload bit, qualified by dec_pybit_vld.
REQ-005 SHALL have port dec_pybit_vld  input  1  one-cycle strobe per payload bit.
REQ-006 SHALL have port py_endp  input  1  one-cycle pulse marking end of payload.
REQ-007 SHALL have port dec_crcgood  input  1  payload CRC result, valid on py_endp.
REQ-008 SHALL have port dec_pylenByte  input  10  decoded payload length in bytes.
REQ-009 SHALL have port rxlnctrl_addr  output  8  word address into the RX payload buffer.
REQ-010 SHALL have port rxlnctrl_din  output  32  packed payload word.
REQ-011 SHALL have port rxlnctrl_we  output  1  one-cycle buffer write strobe.
REQ-012 SHALL have port rxbsm_valid_p  output  1  one-cycle pulse: complete, good payload in buffer.
REQ-013 SHALL have port rx_ovf  output  1  sticky overflow flag, cleared at next payload start.
REQ-014 SHALL have port rx_lenerr  output  1  sticky length-mismatch flag (see REQ-031).

Function
REQ-015 SHALL implement states IDLE, PACK, FLUSH, DONE.
REQ-016 IDLE->PACK SHALL occur on the dec_py_period rising edge, clearing the 13-bit bit counter, accumulator, rx_ovf and rx_lenerr.
REQ-017 In PACK, each dec_pybit_vld SHALL place dec_pybit at accumulator[bitcnt[4:0]] (LSB-first) and increment bitcnt.
REQ-018 When a strobe fills bit 31, rxlnctrl_we SHALL pulse the next cycle with rxlnctrl_addr=bitcnt[12:5] of that word and rxlnctrl_din=the full word; the accumulator then restarts at zero.
REQ-019 py_endp in PACK SHALL move to FLUSH; a bit strobe in the same cycle SHALL be accepted before the transition.
REQ-020 FLUSH SHALL write the partial word (unfilled bits zero) one cycle later if bitcnt[4:0]!=0, otherwise no write; then go to DONE.
REQ-021 DONE SHALL pulse rxbsm_valid_p for one cycle iff the dec_crcgood value latched at py_endp is 1, rx_ovf=0 and rx_lenerr=0; then go to IDLE.
REQ-022 dec_py_period falling in PACK without py_endp SHALL abort to IDLE: no flush write, no rxbsm_valid_p.
REQ-023 Bit 8192 and later SHALL be dropped, rx_ovf set, no address wrap-around write performed.
REQ-024 Strobes outside PACK SHALL be ignored.
REQ-025 rxlnctrl_addr and rxlnctrl_din SHALL hold their last values when rxlnctrl_we=0.
REQ-026 At most one write SHALL be issued per cycle.

Reset
REQ-027 rst SHALL force IDLE, bitcnt=0, accumulator=0 and every output to 0.
REQ-028 rst asserted mid-payload SHALL discard the payload; after release, the block SHALL wait for a new dec_py_period rising edge.

Configuration
REQ-029 Macro PYRX_LENCHK_EN SHALL enable payload length checking.
REQ-030 Without PYRX_LENCHK_EN, rx_lenerr SHALL be tied to 0 and the check logic SHALL be absent.
REQ-031 With PYRX_LENCHK_EN, at py_endp rx_lenerr SHALL be set if bitcnt != dec_pylenByte*8 (13-bit compare).

Structure
REQ-032 Shared package bt_pkg SHALL hold WORD_W=32, ADDR_W=8, MAX_BITS=8192 and the state enum.
REQ-033 One sub-module, pyrx_wordacc (32-bit LSB-first accumulator with clear and bit-index write), SHALL be used.

Verification
REQ-034 40 bits of alternating 1/0 (first bit 1), crcgood=1 -> write addr0 din=0x55555555, then addr1 din=0x00000055, then rxbsm_valid_p.
REQ-035 Exactly 64 bits all 1 with py_endp on the last strobe -> two writes of 0xFFFFFFFF (addr0, addr1), no flush write, valid pulse.
REQ-036 Same as REQ-034 with crcgood=0 -> identical writes, no rxbsm_valid_p.
REQ-037 8200 strobes -> 256 writes (addr 0..255), rx_ovf=1, no valid pulse.
REQ-038 rst asserted after 20 bits, then a new 8-bit payload 0xA5 -> single write addr0 din=0x000000A5, valid pulse.
REQ-039 With PYRX_LENCHK_EN, dec_pylenByte=2 and 24 bits received -> rx_lenerr=1, no valid pulse.
